// File: rtl/rvfi_mem_pkg.sv
// Shared types and helpers for the picorv32 native-bus memory responder.
package rvfi_mem_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} mem_state_t;

  localparam int MODE_FIXED = 0;
  localparam int MODE_NDET  = 1;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  strb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = strb[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/mem_model_ram.sv
// Single-port word RAM with byte enables; read-before-write on the same edge.
module mem_model_ram
  import rvfi_mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  en,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [3:0]            wstrb,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);
  logic [31:0] mem [2**DEPTH_LOG2];

  // Array is intentionally not reset; only the read register is.
  always_ff @(posedge clock)
    if (en) mem[addr] <= merge_bytes(mem[addr], wdata, wstrb);

  always_ff @(posedge clock or negedge resetn)
    if (!resetn)  rdata <= '0;
    else if (en)  rdata <= mem[addr];
endmodule

// File: rtl/rvfi_mem_stall_model.sv
// Bounded-latency picorv32 memory responder with request-side protocol checker.
module rvfi_mem_stall_model
  import rvfi_mem_pkg::*;
#(
  parameter int          MODE       = 0,
  parameter int          MIN_WAIT   = 0,
  parameter int          MAX_WAIT   = 3,
  parameter int          FIXED_WAIT = 1,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0,
  localparam int         W          = $clog2(MAX_WAIT+1)
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         mem_valid,
  input  logic         mem_instr,
  input  logic [31:0]  mem_addr,
  input  logic [31:0]  mem_wdata,
  input  logic [3:0]   mem_wstrb,
  input  logic         stall_req,
  input  logic [31:0]  rdata_rand,
  output logic         mem_ready,
  output logic [31:0]  mem_rdata,
  output logic         busy,
  output logic         proto_err,
  output logic [W-1:0] wait_max
);
  if (!(MIN_WAIT <= FIXED_WAIT && FIXED_WAIT <= MAX_WAIT && MAX_WAIT >= 1 &&
        (MODE == MODE_FIXED || MODE == MODE_NDET) && BASE_ADDR[1:0] == 2'b00)) begin : g_bad_params
    $error("rvfi_mem_stall_model: illegal parameter combination");
  end

  mem_state_t  state;
  logic [W-1:0] cnt;
  logic [31:0] req_addr, req_wdata, rand_q, ram_q;
  logic [3:0]  req_wstrb;
  logic        req_instr, oor_q;
  logic [29:0] idx;
  logic        in_range, done, fire, mismatch;

  // Word index wraps, so addresses below BASE_ADDR land far out of range.
  assign idx      = req_addr[31:2] - BASE_ADDR[31:2];
  assign in_range = (idx >> DEPTH_LOG2) == 30'd0;
  assign fire     = (state == ST_WAIT) && done;
  assign mismatch = (mem_addr != req_addr) || (mem_wdata != req_wdata) ||
                    (mem_wstrb != req_wstrb) || (mem_instr != req_instr);

  always_comb begin
    done = 1'b0;
    if (MODE == MODE_FIXED) done = (cnt == W'(FIXED_WAIT));
    else                    done = (cnt >= W'(MIN_WAIT)) && (!stall_req || cnt == W'(MAX_WAIT));
  end

  mem_model_ram #(.DEPTH_LOG2(DEPTH_LOG2)) u_ram (
    .clock (clock),
    .resetn(resetn),
    .en    (fire && in_range),
    .addr  (idx[DEPTH_LOG2-1:0]),
    .wstrb (req_wstrb),
    .wdata (req_wdata),
    .rdata (ram_q)
  );

  // Both sources are registers captured on the completion edge and held afterwards.
  assign mem_rdata = oor_q ? rand_q : ram_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
      wait_max  <= '0;
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_instr <= 1'b0;
      rand_q    <= '0;
      oor_q     <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          busy <= mem_valid;
          if (mem_valid) begin
            req_addr  <= mem_addr;
            req_wdata <= mem_wdata;
            req_wstrb <= mem_wstrb;
            req_instr <= mem_instr;
            cnt       <= '0;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          busy <= 1'b1;
          if (done) begin
            state     <= ST_RESP;
            mem_ready <= 1'b1;
            oor_q     <= !in_range;
            if (!in_range)      rand_q   <= rdata_rand;
            if (cnt > wait_max) wait_max <= cnt;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
      if ((state == ST_WAIT && !mem_valid) || (state != ST_IDLE && mismatch))
        proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rvfi_mem_stall_model.sv
// Directed plus randomized bench: DUT 0 is fixed-latency, DUT 1 is stall-driven.
module tb_rvfi_mem_stall_model;
  logic clock = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  logic             stall_req;
  logic [31:0]      rdata_rand;
  logic [1:0]       mem_valid, mem_instr, mem_ready, busy, proto_err;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_wstrb;
  logic [1:0][1:0]  wait_max;

  rvfi_mem_stall_model #(.MODE(0), .MIN_WAIT(0), .MAX_WAIT(3), .FIXED_WAIT(1),
                         .DEPTH_LOG2(10), .BASE_ADDR(32'h0)) u_dut0 (
    .clock(clock), .resetn(resetn), .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .stall_req(stall_req), .rdata_rand(rdata_rand), .mem_ready(mem_ready[0]),
    .mem_rdata(mem_rdata[0]), .busy(busy[0]), .proto_err(proto_err[0]), .wait_max(wait_max[0]));

  rvfi_mem_stall_model #(.MODE(1), .MIN_WAIT(1), .MAX_WAIT(3), .FIXED_WAIT(1),
                         .DEPTH_LOG2(10), .BASE_ADDR(32'h100)) u_dut1 (
    .clock(clock), .resetn(resetn), .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .stall_req(stall_req), .rdata_rand(rdata_rand), .mem_ready(mem_ready[1]),
    .mem_rdata(mem_rdata[1]), .busy(busy[1]), .proto_err(proto_err[1]), .wait_max(wait_max[1]));

  int errs = 0, checks = 0;

  // Reference state: RAM words keyed by {dut, word index}, plus per-DUT flags.
  logic [31:0] mdl [longint];
  int          exp_wmax [2];
  bit          exp_perr [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : 32'h100;
  endfunction

  function automatic logic [29:0] widx(input int d, input logic [31:0] a);
    logic [31:0] b;
    b = base_of(d);
    return a[31:2] - b[31:2];
  endfunction

  // One complete transaction. w is the wait count the bench wants for DUT 1;
  // stall_req is shaped so that the stall-driven DUT finishes after exactly w cycles.
  task automatic do_req(input int d, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int w, input logic instr);
    logic [29:0] ix;
    longint      key;
    logic [31:0] exp_rd, nw;
    bit          known, inr;
    ix    = widx(d, a);
    inr   = (ix < 30'd1024);
    key   = (longint'(d) << 32) | longint'(ix);
    known = 1'b0;
    exp_rd = '0;
    if (!inr) begin
      known = 1'b1; exp_rd = rdata_rand;
    end else if (mdl.exists(key)) begin
      known = 1'b1; exp_rd = mdl[key];
    end
    if (d == 0) w = 1;
    mem_valid[d] = 1'b1; mem_addr[d] = a; mem_wdata[d] = wd;
    mem_wstrb[d] = st;   mem_instr[d] = instr;
    stall_req = 1'b1;
    for (int k = 1; k <= 3 + w; k++) begin
      @(posedge clock); #1;
      chk("ready", {31'd0, mem_ready[d]}, {31'd0, k == 2 + w});
      chk("busy",  {31'd0, busy[d]},      {31'd0, k <= 2 + w});
      if (k == 2 + w) begin
        if (known) chk("rdata", mem_rdata[d], exp_rd);
        if (inr && st != 4'h0) begin
          if (known) begin
            for (int i = 0; i < 4; i++)
              nw[8*i +: 8] = st[i] ? wd[8*i +: 8] : exp_rd[8*i +: 8];
            mdl[key] = nw;
          end else if (st == 4'hF) mdl[key] = wd;
        end
        if (w > exp_wmax[d]) exp_wmax[d] = w;
        chk("wait_max", {30'd0, wait_max[d]}, exp_wmax[d]);
        mem_valid[d] = 1'b0;
      end
      if (k - 1 < w)       stall_req = 1'b1;
      else if (k - 1 == w) stall_req = (w == 3) ? 1'($urandom) : 1'b0;
      else                 stall_req = 1'($urandom);
    end
    chk("proto_err", {31'd0, proto_err[d]}, {31'd0, exp_perr[d]});
  endtask

  initial begin
    bit done_wait;
    stall_req = 1'b0; rdata_rand = '0;
    mem_valid = '0; mem_instr = '0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    exp_wmax = '{0, 0}; exp_perr = '{0, 0};

    #2 resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {31'd0, mem_ready[d]}, 32'd0);
      chk("rst_rdata", mem_rdata[d], 32'd0);
      chk("rst_busy",  {31'd0, busy[d]}, 32'd0);
      chk("rst_perr",  {31'd0, proto_err[d]}, 32'd0);
      chk("rst_wmax",  {30'd0, wait_max[d]}, 32'd0);
    end
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;

    // Fixed latency write then read
    do_req(0, 32'h10, 32'hDEADBEEF, 4'hF, 1, 1'b0);
    do_req(0, 32'h10, 32'h0, 4'h0, 1, 1'b0);
    chk("t1_read", mem_rdata[0], 32'hDEADBEEF);

    // Stall held high forces completion at MAX_WAIT
    do_req(1, 32'h100, 32'h01020304, 4'hF, 1, 1'b0);
    do_req(1, 32'h100, 32'h0, 4'h0, 3, 1'b1);
    chk("t2_wmax", {30'd0, wait_max[1]}, 32'd3);
    chk("t2_read", mem_rdata[1], 32'h01020304);

    // Byte strobes
    do_req(0, 32'h20, 32'h11223344, 4'hF, 1, 1'b0);
    do_req(0, 32'h20, 32'hAABBCCDD, 4'h5, 1, 1'b0);
    do_req(0, 32'h20, 32'h0, 4'h0, 1, 1'b0);
    chk("t3_read", mem_rdata[0], 32'h11BB33DD);

    // Out of range, including below BASE_ADDR and the top edge of DUT 1
    do_req(0, 32'h0, 32'h0BADF00D, 4'hF, 1, 1'b0);
    rdata_rand = 32'h5A5A5A5A;
    do_req(0, 32'h4000_0000, 32'h0, 4'h0, 1, 1'b0);
    chk("t4_oor_read", mem_rdata[0], 32'h5A5A5A5A);
    do_req(0, 32'h4000_0000, 32'hFFFFFFFF, 4'hF, 1, 1'b0);
    do_req(0, 32'h0, 32'h0, 4'h0, 1, 1'b0);
    chk("t4_alias", mem_rdata[0], 32'h0BADF00D);
    rdata_rand = 32'hC3C3_0001;
    do_req(1, 32'h0FC, 32'h0, 4'h0, 2, 1'b0);
    chk("t4_below_base", mem_rdata[1], 32'hC3C3_0001);
    do_req(1, 32'h10FC, 32'h77665544, 4'hF, 1, 1'b0);
    do_req(1, 32'h10FC, 32'h0, 4'h0, 2, 1'b0);
    chk("t4_top_word", mem_rdata[1], 32'h77665544);
    rdata_rand = 32'hC3C3_0002;
    do_req(1, 32'h1100, 32'h0, 4'h0, 1, 1'b0);
    chk("t4_past_top", mem_rdata[1], 32'hC3C3_0002);

    // Randomized traffic over a small address pool
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        do_req(d, base_of(d) + 32'(4 * i), $urandom, 4'hF, int'($urandom_range(1, 3)), 1'b0);
    for (int n = 0; n < 40; n++) begin
      int d;
      logic [31:0] a;
      d = int'($urandom_range(0, 1));
      rdata_rand = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'h8000_0000 | 32'($urandom);
      else a = base_of(d) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      do_req(d, a, $urandom, 4'($urandom), int'($urandom_range(1, 3)), 1'($urandom));
    end

    // Protocol: address change during WAIT
    mem_valid[0] = 1'b1; mem_addr[0] = 32'h10; mem_wstrb[0] = 4'h0; mem_wdata[0] = '0; mem_instr[0] = 1'b0;
    @(posedge clock); #1;
    chk("t5_perr_clean", {31'd0, proto_err[0]}, 32'd0);
    mem_addr[0] = 32'h14;
    @(posedge clock); #1;
    chk("t5_perr_addr", {31'd0, proto_err[0]}, 32'd1);
    mem_valid[0] = 1'b0;
    repeat (3) @(posedge clock);
    #1 chk("t5_perr_sticky", {31'd0, proto_err[0]}, 32'd1);
    exp_perr[0] = 1'b1;

    // Protocol: mem_valid dropped during WAIT
    stall_req = 1'b1;
    mem_valid[1] = 1'b1; mem_addr[1] = 32'h100; mem_wstrb[1] = 4'h0; mem_instr[1] = 1'b0;
    @(posedge clock); #1;
    mem_valid[1] = 1'b0;
    @(posedge clock); #1;
    chk("t5_perr_valid", {31'd0, proto_err[1]}, 32'd1);
    exp_perr[1] = 1'b1;
    done_wait = 1'b0;
    for (int k = 0; k < 10 && !done_wait; k++) begin
      @(posedge clock); #1;
      if (!busy[1]) done_wait = 1'b1;
    end
    chk("t5_drain_timeout", {31'd0, done_wait}, 32'd1);

    // Reset in the middle of a write's WAIT
    do_req(0, 32'h30, 32'hCAFEF00D, 4'hF, 1, 1'b0);
    mem_valid[0] = 1'b1; mem_addr[0] = 32'h30; mem_wdata[0] = 32'h12345678; mem_wstrb[0] = 4'hF;
    @(posedge clock); #1;
    chk("t6_busy_pre", {31'd0, busy[0]}, 32'd1);
    resetn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("t6_ready", {31'd0, mem_ready[d]}, 32'd0);
      chk("t6_rdata", mem_rdata[d], 32'd0);
      chk("t6_busy",  {31'd0, busy[d]}, 32'd0);
      chk("t6_perr",  {31'd0, proto_err[d]}, 32'd0);
      chk("t6_wmax",  {30'd0, wait_max[d]}, 32'd0);
    end
    mem_valid = '0;
    exp_perr = '{0, 0}; exp_wmax = '{0, 0};
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
    do_req(0, 32'h30, 32'h0, 4'h0, 1, 1'b0);
    chk("t6_ram_kept", mem_rdata[0], 32'hCAFEF00D);
    do_req(1, 32'h104, 32'h0, 4'h0, 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
